// File: rtl/gate_test_pkg.sv
// -----------------------------------------------------------------------------
// gate_test_pkg
// Shared definitions for the two-input gate test sequencer:
//   - FSM state encoding
//   - number of input vectors applied per pass
//   - reference truth tables, indexed by {a,b}
//   - saturating increment used by the mismatch counter
// -----------------------------------------------------------------------------
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;

  // Bit {a,b} of each table is the gate output expected for that vector.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  // Saturating increment for the 3-bit mismatch count. Only four samples are
  // taken per pass, so saturation is never reached in practice; it just keeps
  // the counter from ever wrapping back to a "clean" value.
  function automatic logic [2:0] err_inc(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd7) begin
      r = v;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_test_hold_cnt.sv
// -----------------------------------------------------------------------------
// gate_test_hold_cnt
// Counts the cycles an input vector has been held on the gate under test.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count -> 0)
//   en   - count this cycle (high while vectors are being driven)
//   clr  - synchronous clear, takes priority over en
//   tc_o - terminal count: high in the cycle whose closing edge is the
//          sample edge (count == HOLD_CYCLES-1 while enabled)
// -----------------------------------------------------------------------------
module gate_test_hold_cnt #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc_o
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear, wrap at the terminal count, or advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// gate_test_sequencer
// Applies the four input vectors {a,b} = 00,01,10,11 to a two-input gate,
// holding each for HOLD_CYCLES cycles, samples the gate output at the end of
// each hold and compares it with a latched expected truth table.
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-high reset
//   start            - one-cycle request to run a pass (honoured in IDLE only)
//   exp_tt[3:0]      - expected truth table, bit {a,b} = expected y
//   y_in             - gate-under-test output, synchronous to clk
//   a_out, b_out     - registered gate inputs
//   busy             - high while a pass runs (DRIVE and DONE)
//   done             - one-cycle pulse at the end of a pass
//   pass             - last completed pass had no mismatches
//   err_cnt[2:0]     - mismatch count of the current / last pass
//   first_fail_valid - a mismatch has been seen in the current / last pass
//   first_fail_idx   - vector index {a,b} of the first mismatch
// -----------------------------------------------------------------------------
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_idx
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] exp_q, exp_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [1:0] ffi_q, ffi_d;

  logic accept_s;
  logic hold_en_s;
  logic tc_s;
  logic mismatch_s;

  // The done pulse is registered out of DONE, so it is visible in the first
  // IDLE cycle; a start in that same cycle must still be ignored.
  assign accept_s   = (state_q == ST_IDLE) && start && !done_q;
  assign hold_en_s  = (state_q == ST_DRIVE);
  assign mismatch_s = (y_in != exp_q[idx_q]);

  gate_test_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold_en_s),
    .clr (accept_s),
    .tc_o(tc_s)
  );

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_DRIVE;
          exp_d   = exp_tt;
          idx_d   = 2'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          ffv_d   = 1'b0;
          ffi_d   = 2'd0;
          busy_d  = 1'b1;
          // Vector 0 is {0,0}, so a/b stay low on the accepting edge.
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRIVE: begin
        busy_d = 1'b1;
        a_d    = idx_q[1];
        b_d    = idx_q[0];
        if (tc_s) begin
          if (mismatch_s) begin
            err_d = err_inc(err_q);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = idx_q;
            end else begin
              ffv_d = ffv_q;
            end
          end else begin
            err_d = err_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            // Advance the vector and present it on the same edge.
            idx_d = idx_q + 2'd1;
            a_d   = idx_d[1];
            b_d   = idx_d[0];
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        idx_d   = 2'd0;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      exp_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      ffv_q   <= 1'b0;
      ffi_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  assign a_out            = a_q;
  assign b_out            = b_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_test_sequencer
// Two sequencers (HOLD_CYCLES=10 and HOLD_CYCLES=2) each drive a behavioural
// gate whose truth table is chosen per pass. Expected results come from the
// truth tables directly: mismatches are the differing bits of gate table vs
// expected table, the first failure is the lowest differing bit, and done
// lands 4*HOLD_CYCLES+1 edges after start.
// -----------------------------------------------------------------------------
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start10 = 1'b0, start2 = 1'b0;
  logic [3:0] exp10 = 4'd0, exp2 = 4'd0;
  logic [3:0] gtt10 = 4'd0, gtt2 = 4'd0;
  logic       y10, y2;

  logic       a10, b10, busy10, done10, pass10, ffv10;
  logic [2:0] err10;
  logic [1:0] ffi10;
  logic       a2, b2, busy2, done2, pass2, ffv2;
  logic [2:0] err2;
  logic [1:0] ffi2;

  // Selected-instance view used by the checks.
  int         sel = 0;
  logic       a_s, b_s, busy_s, done_s, pass_s, ffv_s;
  logic [2:0] err_s;
  logic [1:0] ffi_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural gates under test.
  assign y10 = gtt10[{a10, b10}];
  assign y2  = gtt2[{a2, b2}];

  gate_test_sequencer #(.HOLD_CYCLES(10)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .exp_tt(exp10), .y_in(y10),
    .a_out(a10), .b_out(b10), .busy(busy10), .done(done10), .pass(pass10),
    .err_cnt(err10), .first_fail_valid(ffv10), .first_fail_idx(ffi10)
  );

  gate_test_sequencer #(.HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .exp_tt(exp2), .y_in(y2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail_valid(ffv2), .first_fail_idx(ffi2)
  );

  always_comb begin
    if (sel == 0) begin
      a_s = a10; b_s = b10; busy_s = busy10; done_s = done10;
      pass_s = pass10; err_s = err10; ffv_s = ffv10; ffi_s = ffi10;
    end else begin
      a_s = a2; b_s = b2; busy_s = busy2; done_s = done2;
      pass_s = pass2; err_s = err2; ffv_s = ffv2; ffi_s = ffi2;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ab"},   8'({a_s, b_s}), 8'd0);
    check({tag, "_busy"}, 8'(busy_s), 8'd0);
    check({tag, "_done"}, 8'(done_s), 8'd0);
    check({tag, "_pass"}, 8'(pass_s), 8'd0);
    check({tag, "_err"},  8'(err_s), 8'd0);
    check({tag, "_ffv"},  8'(ffv_s), 8'd0);
    check({tag, "_ffi"},  8'(ffi_s), 8'd0);
  endtask

  // One full pass on instance inst (0: H=10, 1: H=2). extra_start > 0 pulses
  // start again just before that edge number; it must have no effect.
  task automatic run_pass(input int inst, input logic [3:0] gtt, input logic [3:0] ett,
                          input int extra_start);
    int h, lat, exp_err, exp_ffi, done_n, done_at;
    bit exp_ffv;
    h   = (inst == 0) ? 10 : 2;
    lat = 4 * h + 1;
    exp_err = 0; exp_ffv = 1'b0; exp_ffi = 0;
    for (int v = 0; v < 4; v++) begin
      if (gtt[v] !== ett[v]) begin
        exp_err++;
        if (!exp_ffv) begin
          exp_ffv = 1'b1;
          exp_ffi = v;
        end
      end
    end
    sel = inst;
    if (inst == 0) begin gtt10 = gtt; exp10 = ett; start10 = 1'b1; end
    else           begin gtt2  = gtt; exp2  = ett; start2  = 1'b1; end
    tick();
    start10 = 1'b0; start2 = 1'b0;
    // Scramble the table input: the pass must use the latched copy.
    if (inst == 0) exp10 = ~ett; else exp2 = ~ett;
    check("busy_at_start", 8'(busy_s), 8'd1);
    check("vec0_at_start", 8'({a_s, b_s}), 8'd0);
    done_n = 0; done_at = -1;
    for (int k = 1; k <= lat + 3; k++) begin
      if (k == extra_start) begin
        if (inst == 0) start10 = 1'b1; else start2 = 1'b1;
      end
      tick();
      start10 = 1'b0; start2 = 1'b0;
      if (k == 1) begin
        check("cleared_err", 8'(err_s), 8'd0);
        check("cleared_pass", 8'(pass_s), 8'd0);
      end
      if (k < 4 * h) begin
        check("vector_seq", 8'({a_s, b_s}), 8'(k / h));
        check("busy_drive", 8'(busy_s), 8'd1);
      end else if (k == 4 * h) begin
        check("ab_in_done", 8'({a_s, b_s}), 8'd0);
        check("busy_in_done", 8'(busy_s), 8'd1);
      end
      if (done_s) begin
        done_n++;
        done_at = k;
      end
    end
    check("done_latency", 8'(done_at), 8'(lat));
    check("done_count", 8'(done_n), 8'd1);
    check("busy_after", 8'(busy_s), 8'd0);
    check("ab_after", 8'({a_s, b_s}), 8'd0);
    check("pass", 8'(pass_s), 8'(exp_err == 0));
    check("err_cnt", 8'(err_s), 8'(exp_err));
    check("ff_valid", 8'(ffv_s), 8'(exp_ffv));
    check("ff_idx", 8'(ffi_s), 8'(exp_ffi));
  endtask

  initial begin
    int dn;
    // Reset state.
    rst = 1'b1;
    tick(); tick();
    sel = 0; check_all_zero("reset10");
    sel = 1; check_all_zero("reset2");
    rst = 1'b0;
    tick();

    // Correct OR gate against the OR table.
    run_pass(0, TT_OR, TT_OR, 0);
    // Output stuck at 0; a start during the done pulse must be ignored.
    run_pass(0, 4'b0000, 4'b1110, 42);
    // OR gate against the AND table, with a stray start mid-run.
    run_pass(0, TT_OR, TT_AND, 15);

    // Reset in the middle of vector 2.
    sel = 0; gtt10 = TT_OR; exp10 = TT_XOR; start10 = 1'b1;
    tick();
    start10 = 1'b0;
    repeat (24) tick();
    check("mid_vec2", 8'({a_s, b_s}), 8'd2);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    start10 = 1'b1;
    tick(); tick();
    check("start_in_rst", 8'(busy_s), 8'd0);
    start10 = 1'b0;
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done_s) dn++;
    end
    check("no_done_after_abort", 8'(dn), 8'd0);
    check("idle_after_abort", 8'(busy_s), 8'd0);
    run_pass(0, TT_OR, TT_OR, 0);

    // Short hold, output stuck at 1 against OR.
    run_pass(1, 4'b1111, TT_OR, 0);
    run_pass(1, TT_NAND, TT_NAND, 0);

    // Random gates against random tables on both instances.
    for (int r = 0; r < 6; r++) begin
      run_pass(int'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
